mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Sequenced three-port arbiter that shares the single memory bus (mem_read/mem_write/adr_to_mem, mem_busy handshake) between VGA pixel fetch, CPU instruction fetch and CPU data access. It sits between the clients and the memory bus manager and replaces the fixed client rotation with request-driven arbitration. Arbitration is VGA-priority with a starvation cap, plus round-robin between the two CPU ports. Each transaction is latched, issued as a one-cycle command, tracked through mem_busy with a timeout, and completed with a one-cycle ack.

Parameters:
VGA_MAX_STREAK, 4, max consecutive VGA grants while a CPU port is waiting (>=1)
TIMEOUT, 64, max WAIT cycles before a transaction is aborted with error (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
vga_req  in  1  VGA read request; fields stable until vga_ack
vga_adr  in  32  VGA read address
vga_ack  out  1  one-cycle completion pulse
vga_rdata  out  32  read data; valid with vga_ack, held until the next vga_ack
if_req  in  1  instruction fetch request
if_adr  in  32  fetch address
if_ack  out  1  one-cycle completion pulse
if_rdata  out  32  fetched word; held until the next if_ack
d_req  in  1  data request
d_we  in  1  1=write, 0=read
d_adr  in  32  data address
d_wdata  in  32  write data
d_sel  in  4  byte selects
d_ack  out  1  one-cycle completion pulse
d_rdata  out  32  read data; held until the next d_ack; unchanged on writes
d_err  out  1  valid with d_ack; 1 = timed out
mem_busy  in  1  memory manager busy
data_from_mem  in  32  memory read data
mem_read  out  1  read command
mem_write  out  1  write command
adr_to_mem  out  32  address
data_to_mem  out  32  write data
sel_to_mem  out  4  byte selects
grant_id  out  2  0=none, 1=VGA, 2=IF, 3=D; owner of the in-flight transaction

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- On reset: state=IDLE; every output is 0; streak=0; last_cpu=D (so IF wins the first CPU tie); timeout counter=0. A reset asserted mid-transaction drops the transaction with no ack and drives the bus outputs to 0 on the next edge.
- All outputs are registered.

FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE: if any request is high, pick a winner, latch its address, wdata, sel and write flag, set grant_id, go to ISSUE. Otherwise stay, with grant_id=0.
- Winner selection:
  - VGA wins if vga_req and (no CPU request, or streak < VGA_MAX_STREAK).
  - Otherwise a CPU port wins. If both CPU ports request, the one not equal to last_cpu wins.
  - streak increments on each VGA grant (saturating) and clears on any CPU grant.
  - last_cpu updates on each CPU grant.
- ISSUE: hold the command for exactly one cycle.
  - mem_read=1 for VGA, IF, and D with d_we=0.
  - mem_write=1 for D with d_we=1.
  - sel_to_mem=4'hF for all reads except D. D uses the latched d_sel for both reads and writes.
  - data_to_mem is the latched wdata for writes, otherwise 0.
  - Next state WAIT; clear the counter and the seen_busy flag.
- WAIT: mem_read and mem_write are 0; address, data and sel stay held.
  - The counter increments each cycle. mem_busy=1 sets seen_busy.
  - seen_busy && !mem_busy: capture data_from_mem into the owner's rdata (reads only), go to DONE with err=0.
  - counter==TIMEOUT-1 without completion: go to DONE with err=1; rdata is not updated.
- DONE: pulse the owner's ack for one cycle. d_err is valid only with d_ack. Then clear the bus outputs and grant_id, and go to IDLE.
- Minimum latency: req seen at cycle 0, ISSUE at 1, busy high at 2, busy low at 3, ack at cycle 4.
- Requester handshake:
  - A requester must keep its request fields stable until its ack.
  - A request still high in the IDLE cycle after its ack counts as a new transaction. Back-to-back requests are allowed and re-arbitrate.
  - Dropping req before grant withdraws the request. Dropping req after grant has no effect; the transaction still completes.
- Only one transaction is ever outstanding. Requests arriving during ISSUE, WAIT or DONE wait for IDLE.

Test Plan:
- Single IF read, adr=0x100; memory model raises mem_busy at cycle 2, drops it at cycle 3 with data 0xDEADBEEF -> mem_read high only in cycle 1, adr_to_mem=0x100, sel=F, if_ack at cycle 4, if_rdata=0xDEADBEEF.
- D write, adr=0x2000, wdata=0x12345678, sel=4'b0011 -> mem_write one cycle, data_to_mem=0x12345678, sel_to_mem=3, d_ack with d_err=0, d_rdata unchanged.
- vga_req and if_req held high continuously, VGA_MAX_STREAK=4 -> grant_id sequence 1,1,1,1,2,1,1,1,1,2.
- if_req and d_req held high continuously, no VGA -> grants alternate 2,3,2,3, starting with IF after reset.
- mem_busy never asserts, D read -> d_ack with d_err=1 exactly TIMEOUT cycles after entering WAIT; d_rdata keeps its previous value.
- rst pulsed during WAIT of a VGA read -> no vga_ack; all outputs 0 on the next cycle; the next request is arbitrated as after power-up (IF before D).

Source files
------------

// File: rtl/mem_arbiter.sv
// Three-client memory bus arbiter: VGA-priority with a starvation cap, IF/D round-robin,
// one transaction in flight, tracked through mem_busy with a timeout.
module mem_arbiter #(
  parameter int VGA_MAX_STREAK = 4,
  parameter int TIMEOUT        = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_req,
  input  logic [31:0] vga_adr,
  output logic        vga_ack,
  output logic [31:0] vga_rdata,
  input  logic        if_req,
  input  logic [31:0] if_adr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  input  logic        mem_busy,
  input  logic [31:0] data_from_mem,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] adr_to_mem,
  output logic [31:0] data_to_mem,
  output logic [3:0]  sel_to_mem,
  output logic [1:0]  grant_id
);
  localparam int STK_W = $clog2(VGA_MAX_STREAK + 1);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(VGA_MAX_STREAK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] G_NONE = 2'd0, G_VGA = 2'd1, G_IF = 2'd2, G_D = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  state_t state_q, state_d;

  logic [1:0]       grant_id_q, grant_id_d;
  logic             mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [31:0]      adr_q, adr_d, wdata_q, wdata_d;
  logic [3:0]       sel_q, sel_d;
  logic             we_q, we_d, seen_q, seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STK_W-1:0] streak_q, streak_d;
  logic             last_cpu_q, last_cpu_d;  // 1 = D was the last CPU winner
  logic             vga_ack_q, vga_ack_d, if_ack_q, if_ack_d, d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [31:0]      vga_rdata_q, vga_rdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;

  logic cpu_req, any_req, vga_win, if_win, d_win, d_wr, complete, expired;
  assign cpu_req  = if_req | d_req;
  assign any_req  = vga_req | cpu_req;
  assign vga_win  = vga_req && (!cpu_req || (streak_q < STK_MAX));
  assign if_win   = !vga_win && if_req && (!d_req || last_cpu_q);
  assign d_win    = !vga_win && !if_win && d_req;
  assign d_wr     = d_win && d_we;
  assign complete = seen_q && !mem_busy;
  assign expired  = !complete && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (complete || expired) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_id_d  = grant_id_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    we_d        = we_q;
    seen_d      = seen_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    last_cpu_d  = last_cpu_q;
    vga_ack_d   = 1'b0;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    vga_rdata_d = vga_rdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      S_IDLE: if (any_req) begin
        grant_id_d  = vga_win ? G_VGA : (if_win ? G_IF : G_D);
        adr_d       = vga_win ? vga_adr : (if_win ? if_adr : d_adr);
        we_d        = d_wr;
        mem_read_d  = !d_wr;
        mem_write_d = d_wr;
        sel_d       = d_win ? d_sel : 4'hF;
        wdata_d     = d_wr ? d_wdata : 32'h0;
        if (vga_win) begin
          if (streak_q != STK_MAX) streak_d = streak_q + 1'b1;
        end else begin
          streak_d   = '0;
          last_cpu_d = d_win;
        end
      end
      S_ISSUE: begin
        cnt_d  = '0;
        seen_d = 1'b0;
      end
      S_WAIT: begin
        cnt_d  = cnt_q + 1'b1;
        seen_d = seen_q | mem_busy;
        if (complete || expired) begin
          vga_ack_d = (grant_id_q == G_VGA);
          if_ack_d  = (grant_id_q == G_IF);
          d_ack_d   = (grant_id_q == G_D);
          d_err_d   = expired && (grant_id_q == G_D);
          if (complete && !we_q) begin
            case (grant_id_q)
              G_VGA:   vga_rdata_d = data_from_mem;
              G_IF:    if_rdata_d  = data_from_mem;
              G_D:     d_rdata_d   = data_from_mem;
              default: ;
            endcase
          end
        end
      end
      S_DONE: begin
        grant_id_d = G_NONE;
        adr_d      = 32'h0;
        wdata_d    = 32'h0;
        sel_d      = 4'h0;
        we_d       = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id_q  <= G_NONE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      adr_q       <= 32'h0;
      wdata_q     <= 32'h0;
      sel_q       <= 4'h0;
      we_q        <= 1'b0;
      seen_q      <= 1'b0;
      cnt_q       <= '0;
      streak_q    <= '0;
      last_cpu_q  <= 1'b1;
      vga_ack_q   <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      vga_rdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
    end else begin
      grant_id_q  <= grant_id_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      seen_q      <= seen_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      last_cpu_q  <= last_cpu_d;
      vga_ack_q   <= vga_ack_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      vga_rdata_q <= vga_rdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign grant_id    = grant_id_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign adr_to_mem  = adr_q;
  assign data_to_mem = wdata_q;
  assign sel_to_mem  = sel_q;
  assign vga_ack     = vga_ack_q;
  assign if_ack      = if_ack_q;
  assign d_ack       = d_ack_q;
  assign d_err       = d_err_q;
  assign vga_rdata   = vga_rdata_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
endmodule
